ahb_store_buffer: RTL and testbench
===================================

Name: ahb_store_buffer

Overview:
- AHB master-side data-memory port between the CPU DM interface and the AHB fabric (master slot M2).
- Posts CPU stores into a small FIFO so stores complete without a bus round trip, and drains them to the bus as single NONSEQ word transfers.
- Loads hit the buffer by address forwarding; a load miss waits for the drain, then issues a bus read.

Parameters:
- DEPTH, 4, number of store entries (power of 2, ≥2)
- AW, 32, address width
- DW, 32, data width

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU access request; held stable until cpu_ready
- cpu_write  in  1  1 = store, 0 = load
- cpu_addr  in  AW  word address
- cpu_wdata  in  DW  store data
- cpu_rdata  out  DW  load data, valid when cpu_ready && !cpu_write
- cpu_ready  out  1  access complete this cycle
- bus_err  out  1  one-cycle pulse on an ERROR response
- HADDR  out  AW  bus address
- HTRANS  out  2  IDLE=2'b00, NONSEQ=2'b10
- HWRITE  out  1  transfer direction
- HSIZE  out  3  constant 3'b010 (word)
- HWDATA  out  DW  write data
- HBUSREQ  out  1  bus request
- HLOCK  out  1  constant 0
- HGRANT  in  1  grant for this master
- HREADY  in  1  bus ready
- HRDATA  in  DW  read data
- HRESP  in  2  OKAY=2'b00, ERROR=2'b01

Behaviour:
- Reset (async, HRESETn=0): all outputs 0 (HSIZE=3'b010); FIFO count, pointers and valid bits cleared; FSM=IDLE.
- Reset mid-operation: buffered stores are discarded, any in-flight transfer is abandoned, and HTRANS=IDLE immediately.
- FIFO: circular buffer of {addr,data}.
  - count is 0..DEPTH; full = (count==DEPTH).
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
- Store acceptance: if cpu_req && cpu_write && !full (registered full), push and assert cpu_ready the same cycle (combinational). When full, cpu_ready=0 until a pop frees an entry; the push happens in the cycle after the pop. A pop does not bypass into a full-cycle accept.
- Same-address stores are not merged; each store is enqueued.
- Load:
  - Hit (any valid entry address == cpu_addr): cpu_rdata = data of the youngest matching entry; cpu_ready same cycle.
  - Miss: wait until count==0 and FSM==IDLE, then run a bus read; cpu_ready pulses in the read DATA-phase completion cycle with cpu_rdata=HRDATA.
- Bus FSM:
  - IDLE → REQ when count>0 (drain) or a load miss is pending with count==0. Drain has priority.
  - REQ: HBUSREQ=1. → ADDR when HGRANT && HREADY.
  - ADDR: HBUSREQ=1, HTRANS=NONSEQ, HADDR/HWRITE from FIFO head (write) or cpu_addr (read). → DATA when HREADY.
  - DATA: HTRANS=IDLE, HBUSREQ=0, HWDATA=head data (write). When HREADY: pop (write) or complete the load (read), then → IDLE.
- HADDR/HWRITE are held in DATA. Wait states (HREADY=0) hold state and all outputs.
- Latency, granted and no wait states: push in cycle N → REQ N+1 → ADDR N+2 → DATA N+3 → pop at end of N+3.
- ERROR (HRESP=ERROR with HREADY in DATA):
  - bus_err=1 for one cycle.
  - Write: entry popped (dropped).
  - Read: cpu_ready=1 with cpu_rdata=0.
- Forwarding compares against all valid entries, including the head entry currently in flight.

Decomposition:
- Shared package ahb_pkg: HTRANS_IDLE/NONSEQ, HRESP_OKAY/ERROR, HSIZE_WORD, and the FSM state enum (IDLE, REQ, ADDR, DATA).
- One sub-module: sb_fifo (storage, pointers, count, youngest-match forwarding lookup).

Test Plan:
- Single store 0x100←0xDEADBEEF, HGRANT=1, HREADY=1 → cpu_ready in cycle N; NONSEQ write to 0x100 at N+2; HWDATA=0xDEADBEEF at N+3; count back to 0.
- Five back-to-back stores, HGRANT held 0 → first four ready immediately; fifth stalls; fifth accepted the cycle after the first pop once HGRANT=1.
- Stores 0x200←1 then 0x200←2, then load 0x200 with grant held 0 → cpu_ready same cycle, cpu_rdata=2; no bus read issued.
- Store 0x300←5, then load 0x400 (miss) → read NONSEQ to 0x400 only after the write DATA phase completes; cpu_rdata=HRDATA (0x1234).
- Write DATA phase with HREADY=0 for 3 cycles, then HRESP=ERROR → outputs held 3 cycles; bus_err pulses once; entry dropped; count decrements.
- HRESETn low during ADDR phase with 3 entries buffered → HTRANS=IDLE, HBUSREQ=0, count=0 immediately; no transfer after release.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB encodings and the store-buffer bus state machine states.
// Imported by the store buffer and its FIFO.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_ADDR,
    ST_DATA
  } bus_state_e;

endpackage

// File: rtl/sb_fifo.sv
// Circular store queue of {addr,data} with a youngest-match
// forwarding lookup across all valid entries.
module sb_fifo
  import ahb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data,
  output logic [PW:0]   count,
  output logic          full,
  input  logic [AW-1:0] look_addr,
  output logic          hit,
  output logic [DW-1:0] hit_data
);

  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end
      if (push) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (push && !pop)
        count <= count + 1'b1;
      else if (!push && pop)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= push_addr;
      data_q[wr_ptr] <= push_data;
    end
  end

  assign head_addr = addr_q[rd_ptr];
  assign head_data = data_q[rd_ptr];
  assign full      = (count == (PW+1)'(DEPTH));

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (valid[idx] && addr_q[idx] == look_addr) begin
        hit      = 1'b1;
        hit_data = data_q[idx];
      end
    end
  end

endmodule

// File: rtl/ahb_store_buffer.sv
// AHB data-memory master port: posted stores drained as single
// NONSEQ writes, load forwarding, and bus reads on a miss.
module ahb_store_buffer
  import ahb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          cpu_req,
  input  logic          cpu_write,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ready,
  output logic          bus_err,
  output logic [AW-1:0] HADDR,
  output logic [1:0]    HTRANS,
  output logic          HWRITE,
  output logic [2:0]    HSIZE,
  output logic [DW-1:0] HWDATA,
  output logic          HBUSREQ,
  output logic          HLOCK,
  input  logic          HGRANT,
  input  logic          HREADY,
  input  logic [DW-1:0] HRDATA,
  input  logic [1:0]    HRESP
);

  localparam int PW = $clog2(DEPTH);

  bus_state_e    state, state_nx;
  logic          xfer_wr, xfer_wr_nx;
  logic          push, pop, full, hit;
  logic [PW:0]   count;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data, hit_data;
  logic          load_req, load_hit, miss;
  logic          data_done, err, rd_done, in_xfer;

  sb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
    .clk       (HCLK),
    .rst_n     (HRESETn),
    .push      (push),
    .push_addr (cpu_addr),
    .push_data (cpu_wdata),
    .pop       (pop),
    .head_addr (head_addr),
    .head_data (head_data),
    .count     (count),
    .full      (full),
    .look_addr (cpu_addr),
    .hit       (hit),
    .hit_data  (hit_data)
  );

  assign push      = cpu_req && cpu_write && !full;
  assign load_req  = cpu_req && !cpu_write;
  assign load_hit  = load_req && hit;
  assign miss      = load_req && !hit;
  assign data_done = (state == ST_DATA) && HREADY;
  assign err       = data_done && (HRESP == HRESP_ERROR);
  assign pop       = data_done && xfer_wr;
  assign rd_done   = data_done && !xfer_wr;
  assign cpu_ready = push || load_hit || rd_done;

  always_comb begin
    cpu_rdata = '0;
    if (load_hit)
      cpu_rdata = hit_data;
    else if (rd_done && !err)
      cpu_rdata = HRDATA;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= ST_IDLE;
      xfer_wr <= 1'b0;
    end else begin
      state   <= state_nx;
      xfer_wr <= xfer_wr_nx;
    end
  end

  // Draining the queue always wins over a pending load miss.
  always_comb begin
    state_nx   = state;
    xfer_wr_nx = xfer_wr;
    unique case (state)
      ST_IDLE: begin
        if (count != '0 || push) begin
          state_nx   = ST_REQ;
          xfer_wr_nx = 1'b1;
        end else if (miss) begin
          state_nx   = ST_REQ;
          xfer_wr_nx = 1'b0;
        end
      end
      ST_REQ:  if (HGRANT && HREADY) state_nx = ST_ADDR;
      ST_ADDR: if (HREADY) state_nx = ST_DATA;
      ST_DATA: if (HREADY) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  assign in_xfer = (state == ST_ADDR) || (state == ST_DATA);
  assign HBUSREQ = (state == ST_REQ) || (state == ST_ADDR);
  assign HTRANS  = (state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR   = in_xfer ? (xfer_wr ? head_addr : cpu_addr) : '0;
  assign HWRITE  = in_xfer && xfer_wr;
  assign HWDATA  = (state == ST_DATA && xfer_wr) ? head_data : '0;
  assign HSIZE   = HSIZE_WORD;
  assign HLOCK   = 1'b0;
  assign bus_err = err;

endmodule

// File: tb/tb_ahb_store_buffer.sv
// Directed bench for ahb_store_buffer: a cycle vector table plus
// hand sequences for stall, miss, wait/error and mid-transfer reset.
module tb_ahb_store_buffer;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        cpu_req = 1'b0, cpu_write = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
  logic        cpu_ready, bus_err;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HBUSREQ, HLOCK;
  logic [2:0]  HSIZE;
  logic        HGRANT = 1'b0, HREADY = 1'b1;
  logic [31:0] HRDATA = '0;
  logic [1:0]  HRESP = 2'b00;

  int checks = 0;
  int failures = 0;

  always #5 HCLK = ~HCLK;

  ahb_store_buffer dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cpu_req(cpu_req), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .bus_err(bus_err), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HBUSREQ(HBUSREQ), .HLOCK(HLOCK), .HGRANT(HGRANT),
    .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
  );

  typedef struct {
    logic        rst;
    logic        req, wr;
    logic [31:0] addr, wdata;
    logic        grant;
    logic        e_ready;
    logic [31:0] e_rdata;
    logic [1:0]  e_htrans;
    logic        e_busreq;
    logic        ca;
    logic [31:0] e_haddr;
    logic        e_hwrite;
    logic        cw;
    logic [31:0] e_hwdata;
    logic [2:0]  e_count;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    cpu_req = 1'b0; cpu_write = 1'b0;
    cpu_addr = '0; cpu_wdata = '0;
    HGRANT = 1'b0; HREADY = 1'b1; HRDATA = '0; HRESP = 2'b00;
    @(posedge HCLK); #2;
    chk("rst_ready", 32'(cpu_ready), 32'd0);
    chk("rst_htrans", 32'(HTRANS), 32'd0);
    chk("rst_busreq", 32'(HBUSREQ), 32'd0);
    chk("rst_haddr", HADDR, 32'd0);
    chk("rst_hwrite", 32'(HWRITE), 32'd0);
    chk("rst_hwdata", HWDATA, 32'd0);
    chk("rst_hsize", 32'(HSIZE), 32'd2);
    chk("rst_hlock", 32'(HLOCK), 32'd0);
    chk("rst_err", 32'(bus_err), 32'd0);
    chk("rst_count", 32'(dut.u_fifo.count), 32'd0);
    @(posedge HCLK); #3;
    HRESETn = 1'b1;
  endtask

  // Advance to the next cycle, then let combinational outputs settle.
  task automatic cyc();
    @(posedge HCLK); #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic vec_t mk(
    logic rst, logic req, logic wr, logic [31:0] addr,
    logic [31:0] wdata, logic grant, logic e_ready,
    logic [31:0] e_rdata, logic [1:0] e_htrans, logic e_busreq,
    logic ca, logic [31:0] e_haddr, logic e_hwrite,
    logic cw, logic [31:0] e_hwdata, logic [2:0] e_count);
    vec_t v;
    v.rst = rst; v.req = req; v.wr = wr; v.addr = addr;
    v.wdata = wdata; v.grant = grant; v.e_ready = e_ready;
    v.e_rdata = e_rdata; v.e_htrans = e_htrans;
    v.e_busreq = e_busreq; v.ca = ca; v.e_haddr = e_haddr;
    v.e_hwrite = e_hwrite; v.cw = cw; v.e_hwdata = e_hwdata;
    v.e_count = e_count;
    return v;
  endfunction

  initial begin
    // single store drained with no wait states
    tbl[0] = mk(1,1,1,32'h100,32'hDEADBEEF,1, 1,0,2'b00,0, 0,0,0, 0,0, 0);
    tbl[1] = mk(0,0,0,32'h0,  32'h0,       1, 0,0,2'b00,1, 0,0,0, 0,0, 1);
    tbl[2] = mk(0,0,0,32'h0,  32'h0,       1, 0,0,2'b10,1, 1,32'h100,1, 0,0, 1);
    tbl[3] = mk(0,0,0,32'h0,  32'h0,       1, 0,0,2'b00,0, 1,32'h100,1,
                1,32'hDEADBEEF, 1);
    tbl[4] = mk(0,0,0,32'h0,  32'h0,       1, 0,0,2'b00,0, 0,0,0, 0,0, 0);
    // youngest-entry forwarding with the bus withheld
    tbl[5] = mk(1,1,1,32'h200,32'h1,0, 1,0,2'b00,0, 0,0,0, 0,0, 0);
    tbl[6] = mk(0,1,1,32'h200,32'h2,0, 1,0,2'b00,1, 0,0,0, 0,0, 1);
    tbl[7] = mk(0,1,0,32'h200,32'h0,0, 1,32'h2,2'b00,1, 0,0,0, 0,0, 2);
    tbl[8] = mk(0,0,0,32'h0,  32'h0,0, 0,0,2'b00,1, 0,0,0, 0,0, 2);

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].rst) do_reset();
      cyc();
      cpu_req = tbl[i].req; cpu_write = tbl[i].wr;
      cpu_addr = tbl[i].addr; cpu_wdata = tbl[i].wdata;
      HGRANT = tbl[i].grant;
      settle();
      chk($sformatf("v%0d_ready", i), 32'(cpu_ready), 32'(tbl[i].e_ready));
      if (tbl[i].e_ready && !tbl[i].wr)
        chk($sformatf("v%0d_rdata", i), cpu_rdata, tbl[i].e_rdata);
      chk($sformatf("v%0d_htrans", i), 32'(HTRANS), 32'(tbl[i].e_htrans));
      chk($sformatf("v%0d_busreq", i), 32'(HBUSREQ), 32'(tbl[i].e_busreq));
      if (tbl[i].ca) begin
        chk($sformatf("v%0d_haddr", i), HADDR, tbl[i].e_haddr);
        chk($sformatf("v%0d_hwrite", i), 32'(HWRITE), 32'(tbl[i].e_hwrite));
      end
      if (tbl[i].cw)
        chk($sformatf("v%0d_hwdata", i), HWDATA, tbl[i].e_hwdata);
      chk($sformatf("v%0d_count", i), 32'(dut.u_fifo.count),
          32'(tbl[i].e_count));
      chk($sformatf("v%0d_err", i), 32'(bus_err), 32'd0);
    end

    // five stores against a full queue, grant withheld
    do_reset();
    for (int k = 0; k < 6; k++) begin
      cyc();
      cpu_req = 1'b1; cpu_write = 1'b1;
      cpu_addr = (k < 4) ? 32'h10 + 32'(k) : 32'h20;
      cpu_wdata = 32'hA0 + 32'(k);
      settle();
      chk($sformatf("fill%0d_ready", k), 32'(cpu_ready),
          (k < 4) ? 32'd1 : 32'd0);
    end
    chk("fill_count", 32'(dut.u_fifo.count), 32'd4);
    for (int k = 0; k < 4; k++) begin
      cyc();
      HGRANT = 1'b1;
      settle();
      chk($sformatf("stall%0d_ready", k), 32'(cpu_ready),
          (k == 3) ? 32'd1 : 32'd0);
      if (k == 1) begin
        chk("stall_htrans", 32'(HTRANS), 32'd2);
        chk("stall_haddr", HADDR, 32'h10);
      end
      if (k == 2) chk("stall_hwdata", HWDATA, 32'hA0);
      if (k == 3) chk("stall_count", 32'(dut.u_fifo.count), 32'd3);
    end
    cyc();
    cpu_req = 1'b0;
    settle();
    chk("fifth_count", 32'(dut.u_fifo.count), 32'd4);

    // store then load miss: read must follow the write drain
    do_reset();
    HGRANT = 1'b1;
    cyc();
    cpu_req = 1'b1; cpu_write = 1'b1;
    cpu_addr = 32'h300; cpu_wdata = 32'h5;
    settle();
    chk("miss_st_ready", 32'(cpu_ready), 32'd1);
    cyc();
    cpu_write = 1'b0; cpu_addr = 32'h400; HRDATA = 32'h1234;
    for (int k = 1; k < 8; k++) begin
      settle();
      chk($sformatf("miss%0d_ready", k), 32'(cpu_ready),
          (k == 7) ? 32'd1 : 32'd0);
      if (k == 2) chk("miss_wr_haddr", HADDR, 32'h300);
      if (k == 3) chk("miss_wr_hwdata", HWDATA, 32'h5);
      chk($sformatf("miss%0d_htrans", k), 32'(HTRANS),
          (k == 2 || k == 6) ? 32'd2 : 32'd0);
      if (k == 6) begin
        chk("miss_rd_haddr", HADDR, 32'h400);
        chk("miss_rd_hwrite", 32'(HWRITE), 32'd0);
      end
      if (k == 7) chk("miss_rdata", cpu_rdata, 32'h1234);
      if (k < 7) cyc();
    end
    cyc();
    cpu_req = 1'b0;

    // wait states then ERROR on a write data phase
    do_reset();
    HGRANT = 1'b1;
    cyc();
    cpu_req = 1'b1; cpu_write = 1'b1;
    cpu_addr = 32'h500; cpu_wdata = 32'h7;
    settle();
    cyc(); cpu_req = 1'b0;
    cyc();
    for (int k = 0; k < 3; k++) begin
      cyc();
      HREADY = 1'b0;
      settle();
      chk($sformatf("ws%0d_haddr", k), HADDR, 32'h500);
      chk($sformatf("ws%0d_hwrite", k), 32'(HWRITE), 32'd1);
      chk($sformatf("ws%0d_hwdata", k), HWDATA, 32'h7);
      chk($sformatf("ws%0d_htrans", k), 32'(HTRANS), 32'd0);
      chk($sformatf("ws%0d_err", k), 32'(bus_err), 32'd0);
      chk($sformatf("ws%0d_count", k), 32'(dut.u_fifo.count), 32'd1);
    end
    cyc();
    HREADY = 1'b1; HRESP = 2'b01;
    settle();
    chk("err_pulse", 32'(bus_err), 32'd1);
    cyc();
    HRESP = 2'b00;
    settle();
    chk("err_clear", 32'(bus_err), 32'd0);
    chk("err_count", 32'(dut.u_fifo.count), 32'd0);
    chk("err_htrans", 32'(HTRANS), 32'd0);

    // reset asserted during an address phase
    do_reset();
    for (int k = 0; k < 3; k++) begin
      cyc();
      cpu_req = 1'b1; cpu_write = 1'b1;
      cpu_addr = 32'h600 + 32'(k); cpu_wdata = 32'(k);
    end
    cyc();
    cpu_req = 1'b0; HGRANT = 1'b1;
    cyc();
    settle();
    chk("mr_htrans_pre", 32'(HTRANS), 32'd2);
    chk("mr_count_pre", 32'(dut.u_fifo.count), 32'd3);
    #1 HRESETn = 1'b0;
    #1;
    chk("mr_htrans", 32'(HTRANS), 32'd0);
    chk("mr_busreq", 32'(HBUSREQ), 32'd0);
    chk("mr_count", 32'(dut.u_fifo.count), 32'd0);
    @(posedge HCLK); #3;
    HRESETn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      settle();
      chk($sformatf("mr%0d_htrans", k), 32'(HTRANS), 32'd0);
      chk($sformatf("mr%0d_busreq", k), 32'(HBUSREQ), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
